// File: rtl/crc_pkg.sv
// Shared constants and types for the serial CRC generator/checker pair.
package crc_pkg;

    localparam int         CRC_WIDTH_DEF = 8;
    localparam logic [7:0] POLY_DEF      = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/crc_lfsr.sv
// Serial data-into-LSB CRC LFSR with clear and enable, shared by the CRC generator and checker.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH  = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = CRC_WIDTH'(POLY_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic [CRC_WIDTH-1:0] value
);

    logic [CRC_WIDTH-1:0] lfsr_reg;
    logic [CRC_WIDTH-1:0] base;
    logic [CRC_WIDTH-1:0] step_next;

    // A clear with enable restarts from zero and consumes the bit in the same cycle.
    assign base = clr ? '0 : lfsr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CRC_WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign step_next[gi] = din ^ (base[CRC_WIDTH-1] & POLYNOMIAL[gi]);
            end else begin : g_upper
                assign step_next[gi] = base[gi-1] ^ (base[CRC_WIDTH-1] & POLYNOMIAL[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= '0;
        end else if (en) begin
            lfsr_reg <= step_next;
        end else if (clr) begin
            lfsr_reg <= '0;
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/crc_checker.sv
// Serial CRC receiver: captures DATA_BITS payload bits, checks the trailing CRC field.
// Optional saturating error counter enabled by defining CRC_CHK_ERR_CNT_EN.
module crc_checker
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH  = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = CRC_WIDTH'(POLY_DEF),
    parameter int                   DATA_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 data_valid,
    input  logic                 data_in,
`ifdef CRC_CHK_ERR_CNT_EN
    input  logic                 err_count_clr,
    output logic [7:0]           err_count,
`endif
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 crc_ok,
    output logic                 crc_err
);

    localparam int CNT_MAX = (DATA_BITS > CRC_WIDTH) ? DATA_BITS : CRC_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    chk_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 ok_reg, err_reg;
    logic [CRC_WIDTH-1:0] lfsr_value;
    logic                 lfsr_en;
    logic                 shift_en;
    logic                 lfsr_zero;
    logic                 done_valid;

    assign lfsr_en   = data_valid && (frame_start || state_reg == ST_DATA || state_reg == ST_CHECK);
    assign shift_en  = data_valid && (frame_start || state_reg == ST_DATA);
    assign lfsr_zero = (lfsr_value == '0);
    // A frame_start landing on the DONE cycle aborts that frame's report.
    assign done_valid = (state_reg == ST_DONE) && !frame_start;

    crc_lfsr #(
        .CRC_WIDTH  (CRC_WIDTH),
        .POLYNOMIAL (POLYNOMIAL)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .en    (lfsr_en),
        .din   (data_in),
        .value (lfsr_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (frame_start) begin
            if (data_valid && DATA_BITS == 1) begin
                state_next = ST_CHECK;
                cnt_next   = '0;
            end else begin
                state_next = ST_DATA;
                cnt_next   = data_valid ? CNT_W'(1) : '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_DATA: begin
                    if (data_valid) begin
                        if (cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                            state_next = ST_CHECK;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (data_valid) begin
                        if (cnt_reg == CNT_W'(CRC_WIDTH - 1)) begin
                            state_next = ST_DONE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // The verdict is live from the LFSR during DONE and held in ok_reg/err_reg afterwards.
    always_comb begin
        busy       = (state_reg == ST_DATA) || (state_reg == ST_CHECK);
        frame_done = done_valid;
        crc_ok     = done_valid ? lfsr_zero  : ok_reg;
        crc_err    = done_valid ? !lfsr_zero : err_reg;
    end

    genvar gi;
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign data_next = data_in;
        end else begin : g_shift_many
            assign data_next = {data_reg[DATA_BITS-2:0], data_in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (shift_en) begin
            data_reg <= data_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else if (frame_start) begin
            ok_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else if (done_valid) begin
            ok_reg  <= lfsr_zero;
            err_reg <= !lfsr_zero;
        end
    end

    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_out
            assign data_out[gi] = data_reg[gi];
        end
    endgenerate

`ifdef CRC_CHK_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (err_count_clr) begin
            err_cnt_reg <= '0;
        end else if (done_valid && !lfsr_zero && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_count = err_cnt_reg;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Scoreboard bench for crc_checker (DATA_BITS=8, CRC-8 poly 0x07).
module tb_crc_checker;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          data_valid = 1'b0;
    logic          data_in = 1'b0;
    logic          busy;
    logic [DB-1:0] data_out;
    logic          frame_done;
    logic          crc_ok;
    logic          crc_err;
`ifdef CRC_CHK_ERR_CNT_EN
    logic          err_count_clr = 1'b0;
    logic [7:0]    err_count;
`endif

    crc_checker #(
        .CRC_WIDTH  (8),
        .POLYNOMIAL (8'h07),
        .DATA_BITS  (DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .data_valid    (data_valid),
        .data_in       (data_in),
`ifdef CRC_CHK_ERR_CNT_EN
        .err_count_clr (err_count_clr),
        .err_count     (err_count),
`endif
        .busy          (busy),
        .data_out      (data_out),
        .frame_done    (frame_done),
        .crc_ok        (crc_ok),
        .crc_err       (crc_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ok;
        int         done_cyc;
        int         start_cyc;
        int         lat;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  n_done = 0;
    int  busy_gaps = 0;
    bit  track_busy = 1'b0;
    int  start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic b);
        logic [7:0] n;
        n = {l[6:0], b};
        if (l[7]) n = n ^ 8'h07;
        return n;
    endfunction

    // Generator-side CRC: payload followed by eight zero bits.
    function automatic logic [7:0] gen_crc(input logic [7:0] payload);
        logic [7:0] l;
        l = '0;
        for (int i = 7; i >= 0; i--) l = lfsr_step(l, payload[i]);
        for (int i = 0; i < 8; i++) l = lfsr_step(l, 1'b0);
        return l;
    endfunction

    task automatic drive(input logic fs, input logic dv, input logic d);
        frame_start = fs;
        data_valid  = dv;
        data_in     = d;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        data_in     = 1'b0;
    endtask

    // Sends the first nbits of {payload, crc}; only complete frames enter the scoreboard.
    task automatic send_frame(input logic [7:0] payload, input logic [7:0] crc, input int nbits,
                              input bit stall, input logic exp_ok, input int exp_lat);
        logic [15:0] bits;
        sb_t e;
        bits = {payload, crc};
        for (int i = 0; i < nbits; i++) begin
            if (stall && i > 0) drive(1'b0, 1'b0, 1'b0);
            if (i == 0) start_cyc = cyc;
            if (i == 1 && stall) track_busy = 1'b1;
            if (i == 15) begin
                e.data = payload; e.ok = exp_ok; e.done_cyc = cyc + 1;
                e.start_cyc = start_cyc; e.lat = exp_lat;
                sb_q.push_back(e);
            end
            drive(i == 0, 1'b1, bits[15-i]);
        end
        track_busy = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int k = 0; k < 60 && n_done < target; k++) @(posedge clk);
        #1;
        check("frame_done_seen", n_done, target);
    endtask

    task automatic monitor_loop();
        sb_t e;
        forever begin
            @(negedge clk);
            if (track_busy && !busy) busy_gaps++;
            if (rst_n && frame_done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    check("spurious_done", frame_done, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    $display("frame %0d: data_out=%02h crc_ok=%0b crc_err=%0b at cycle %0d",
                             n_done, data_out, crc_ok, crc_err, cyc);
                    check("data_out", data_out, e.data);
                    check("crc_ok", crc_ok, e.ok);
                    check("crc_err", crc_err, !e.ok);
                    check("done_cycle", cyc, e.done_cyc);
                    // Cycles from the frame_start cycle through the frame_done cycle, inclusive.
                    if (e.lat != 0) check("latency", cyc - e.start_cyc + 1, e.lat);
                end
            end
        end
    endtask

    logic [7:0] rp;

    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_done", frame_done, 1'b0);
        check("rst_ok", crc_ok, 1'b0);
        check("rst_err", crc_err, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // Valid bits without frame_start are ignored.
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        check("idle_busy", busy, 1'b0);

        send_frame(8'h01, 8'h07, 16, 1'b0, 1'b1, 17);
        wait_frames(1);
        drive(1'b0, 1'b0, 1'b0);
        check("busy_after_done", busy, 1'b0);
        check("ok_hold", crc_ok, 1'b1);

        send_frame(8'h80, 8'h89, 16, 1'b0, 1'b1, 17);
        wait_frames(2);

        // frame_start with data_valid low clears the verdict and enters the frame.
        drive(1'b1, 1'b0, 1'b0);
        check("ok_clear", crc_ok, 1'b0);
        check("busy_after_start", busy, 1'b1);

        send_frame(8'h00, 8'h00, 16, 1'b0, 1'b1, 17);
        wait_frames(3);

        send_frame(8'h01, 8'h06, 16, 1'b0, 1'b0, 17);
        wait_frames(4);
        drive(1'b0, 1'b0, 1'b0);
        check("err_hold", crc_err, 1'b1);
`ifdef CRC_CHK_ERR_CNT_EN
        check("err_count_1", err_count, 8'd1);
        err_count_clr = 1'b1;
        @(posedge clk);
        #1;
        err_count_clr = 1'b0;
        check("err_count_clr", err_count, 8'd0);
`endif

        send_frame(8'h80, 8'h89, 16, 1'b1, 1'b1, 0);
        wait_frames(5);
        check("stall_busy_gaps", busy_gaps, 0);

        // Abort after 5 payload bits, then a full good frame.
        send_frame(8'hFF, 8'h00, 5, 1'b0, 1'b0, 0);
        send_frame(8'h01, 8'h07, 16, 1'b0, 1'b1, 17);
        wait_frames(6);

        // Reset 12 bits into a frame.
        send_frame(8'hA5, gen_crc(8'hA5), 12, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", data_out, 8'h00);
        check("midrst_ok", crc_ok, 1'b0);
        check("midrst_err", crc_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) drive(1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 8'h07, 16, 1'b0, 1'b1, 17);
        wait_frames(7);

        for (int t = 0; t < 3; t++) begin
            rp = 8'($urandom_range(0, 255));
            send_frame(rp, gen_crc(rp), 16, 1'b0, 1'b1, 17);
            wait_frames(8 + t);
        end
        rp = 8'($urandom_range(0, 255));
        send_frame(rp, gen_crc(rp) ^ 8'h10, 16, 1'b0, 1'b0, 17);
        wait_frames(11);
`ifdef CRC_CHK_ERR_CNT_EN
        check("err_count_end", err_count, 8'd1);
`endif

        repeat (5) drive(1'b0, 1'b0, 1'b0);
        check("sb_empty", sb_q.size(), 0);
        check("done_total", n_done, 11);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Serial CRC receiver/checker; the receive-side counterpart of the team's serial CRC generator.
- Takes an MSB-first bit stream of DATA_BITS payload bits followed by CRC_WIDTH check bits.
- Runs every bit through the same data-into-LSB LFSR the generator uses, then flags pass/fail and presents the captured payload word.
- Sits between the line deserialiser and the packet layer.

Parameters:
- CRC_WIDTH, 8, width of the CRC register and of the trailing check field.
- POLYNOMIAL, 8'h07, generator polynomial without the implicit top bit; must match the transmitter.
- DATA_BITS, 32, payload bits per frame; legal range 1 to 1024.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  pulse marking that the bit on data_in this cycle, if data_valid is high, is payload bit 0 (MSB).
- data_valid  input  1  qualifies data_in; no bit is consumed while low.
- data_in  input  1  serial bit.
- busy  output  1  high while a frame is being received.
- data_out  output  DATA_BITS  captured payload, MSB = first received bit.
- frame_done  output  1  one-cycle pulse when a frame completes.
- crc_ok  output  1  last frame's remainder was zero.
- crc_err  output  1  last frame's remainder was non-zero.

Behaviour:
- Reset (async, rst_n low): state=IDLE, LFSR=0, bit counter=0, data_out=0, busy=0, frame_done=0, crc_ok=0, crc_err=0.
- LFSR step (same as generator) on every consumed bit: next = {lfsr[CRC_WIDTH-2:0], data_in}; if lfsr[CRC_WIDTH-1] was 1, XOR next with POLYNOMIAL.
- Feeding the payload followed by the generator's CRC leaves LFSR=0 exactly when the frame is intact.
- States:
  - IDLE: waits for frame_start. On frame_start with data_valid high, the LFSR is cleared and the bit is consumed as payload bit 0; go to DATA with counter=1. On frame_start with data_valid low, the LFSR is cleared and the state goes to DATA with counter=0. busy=1 from the cycle after frame_start.
  - DATA: each valid bit steps the LFSR and shifts into data_out from the LSB side (data_out <= {data_out[DATA_BITS-2:0], data_in}). After DATA_BITS bits, go to CHECK with counter=0. data_out changes only in DATA.
  - CHECK: each valid bit steps the LFSR only. When the CRC_WIDTH-th bit is consumed, go to DONE.
  - DONE: a single cycle. frame_done=1. crc_ok=(lfsr==0), crc_err=!crc_ok. busy=0. Return to IDLE.
  - Latency: frame_done is high on the cycle after the final CRC bit is sampled.
- crc_ok and crc_err hold until the next frame_start is accepted; both clear on that frame_start.
- frame_start while in DATA, CHECK or DONE aborts the current frame and restarts as from IDLE:
  - no frame_done for the aborted frame;
  - data_out keeps its partially shifted content.
- data_valid low mid-frame stalls everything; there is no timeout.
- data_valid bits in IDLE without frame_start are ignored.
- Reset mid-frame discards the frame immediately; no frame_done is produced.

Optional Feature:
- Macro: CRC_CHK_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments on every frame_done with crc_err; saturates at 8'hFF.
  - Adds input err_count_clr (1 bit), a synchronous clear; clear wins over a simultaneous increment.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package crc_pkg:
  - default CRC_WIDTH and POLYNOMIAL constants;
  - checker state typedef (IDLE, DATA, CHECK, DONE).
- One natural sub-module, crc_lfsr: serial LFSR with clear and enable, parameterised by CRC_WIDTH and POLYNOMIAL, exposing the register value. It is intended for reuse by the generator.
- The checker owns the counter, the FSM and the payload shift register.

Test Plan (DATA_BITS=8, CRC_WIDTH=8, POLYNOMIAL=8'h07, data_valid continuous unless stated):
- Payload 0x01 + CRC 0x07 -> frame_done 17 cycles after frame_start, crc_ok=1, crc_err=0, data_out=0x01.
- Payload 0x80 + CRC 0x89 -> crc_ok=1, data_out=0x80. Payload 0x00 + CRC 0x00 -> crc_ok=1.
- Payload 0x01 + CRC 0x06 (single-bit error) -> crc_err=1, crc_ok=0; with CRC_CHK_ERR_CNT_EN, err_count=1, and err_count_clr returns it to 0.
- Payload 0x80 + CRC 0x89 with data_valid low on every other cycle -> the same result, frame_done after the 16th valid bit, busy held throughout.
- frame_start reasserted after 5 payload bits, then a full good frame 0x01/0x07 -> exactly one frame_done, crc_ok=1, data_out=0x01.
- rst_n pulsed low after 12 bits -> all outputs 0 immediately, no frame_done; the next good frame passes.
